// File: rtl/tns_decoder_31_pipe.sv
// Three-stage pipelined decoder for 31-bit TNS codewords.
// Each set code bit contributes a fixed weight. The weights form a tribonacci
// series: bit0=1, bit1=2, bit2=4, and every later weight is the sum of the
// three weights below it. The data word is the sum of the weights of the set
// bits. One extra accumulator bit flags sums that do not fit the data width.
// Weights of bits 30..21 are added ahead of stage S1, bits 20..11 ahead of S2,
// and bits 10..0 ahead of S3. A valid/ready handshake with full backpressure
// sits on each side.
module tns_decoder_31_pipe (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [30:0] code_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [26:0] data_out,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int BLEN11_C = 27;
    localparam int ACC_W    = BLEN11_C + 1;

    // Weight table. Group gg sits on bits 3g-1 (A), 3g-2 (B) and 3g-3 (C).
    // Bit 30 is the lone C weight of group 11.
    localparam logic [ACC_W-1:0] TNS01_C = 28'd1;
    localparam logic [ACC_W-1:0] TNS01_B = 28'd2;
    localparam logic [ACC_W-1:0] TNS01_A = 28'd4;
    localparam logic [ACC_W-1:0] TNS02_C = 28'd7;
    localparam logic [ACC_W-1:0] TNS02_B = 28'd13;
    localparam logic [ACC_W-1:0] TNS02_A = 28'd24;
    localparam logic [ACC_W-1:0] TNS03_C = 28'd44;
    localparam logic [ACC_W-1:0] TNS03_B = 28'd81;
    localparam logic [ACC_W-1:0] TNS03_A = 28'd149;
    localparam logic [ACC_W-1:0] TNS04_C = 28'd274;
    localparam logic [ACC_W-1:0] TNS04_B = 28'd504;
    localparam logic [ACC_W-1:0] TNS04_A = 28'd927;
    localparam logic [ACC_W-1:0] TNS05_C = 28'd1705;
    localparam logic [ACC_W-1:0] TNS05_B = 28'd3136;
    localparam logic [ACC_W-1:0] TNS05_A = 28'd5768;
    localparam logic [ACC_W-1:0] TNS06_C = 28'd10609;
    localparam logic [ACC_W-1:0] TNS06_B = 28'd19513;
    localparam logic [ACC_W-1:0] TNS06_A = 28'd35890;
    localparam logic [ACC_W-1:0] TNS07_C = 28'd66012;
    localparam logic [ACC_W-1:0] TNS07_B = 28'd121415;
    localparam logic [ACC_W-1:0] TNS07_A = 28'd223317;
    localparam logic [ACC_W-1:0] TNS08_C = 28'd410744;
    localparam logic [ACC_W-1:0] TNS08_B = 28'd755476;
    localparam logic [ACC_W-1:0] TNS08_A = 28'd1389537;
    localparam logic [ACC_W-1:0] TNS09_C = 28'd2555757;
    localparam logic [ACC_W-1:0] TNS09_B = 28'd4700770;
    localparam logic [ACC_W-1:0] TNS09_A = 28'd8646064;
    localparam logic [ACC_W-1:0] TNS10_C = 28'd15902591;
    localparam logic [ACC_W-1:0] TNS10_B = 28'd29249425;
    localparam logic [ACC_W-1:0] TNS10_A = 28'd53798080;
    localparam logic [ACC_W-1:0] TNS11_C = 28'd98950096;

    // Weight of code bit k. Indices outside the codeword weigh nothing.
    function automatic logic [ACC_W-1:0] tns_weight(input int k);
        logic [ACC_W-1:0] w;
        case (k)
            0:       w = TNS01_C;
            1:       w = TNS01_B;
            2:       w = TNS01_A;
            3:       w = TNS02_C;
            4:       w = TNS02_B;
            5:       w = TNS02_A;
            6:       w = TNS03_C;
            7:       w = TNS03_B;
            8:       w = TNS03_A;
            9:       w = TNS04_C;
            10:      w = TNS04_B;
            11:      w = TNS04_A;
            12:      w = TNS05_C;
            13:      w = TNS05_B;
            14:      w = TNS05_A;
            15:      w = TNS06_C;
            16:      w = TNS06_B;
            17:      w = TNS06_A;
            18:      w = TNS07_C;
            19:      w = TNS07_B;
            20:      w = TNS07_A;
            21:      w = TNS08_C;
            22:      w = TNS08_B;
            23:      w = TNS08_A;
            24:      w = TNS09_C;
            25:      w = TNS09_B;
            26:      w = TNS09_A;
            27:      w = TNS10_C;
            28:      w = TNS10_B;
            29:      w = TNS10_A;
            30:      w = TNS11_C;
            default: w = {ACC_W{1'b0}};
        endcase
        return w;
    endfunction

    // Pipeline state.
    logic             s1_v_q, s2_v_q, s3_v_q;
    logic [ACC_W-1:0] s1_acc_q, s2_acc_q, s3_acc_q;
    logic [ACC_W-1:0] s1_acc_d, s2_acc_d, s3_acc_d;
    logic [20:0]      s1_bits_q;
    logic [10:0]      s2_bits_q;

    // Stage load enables. A stage loads when it is empty or when its
    // successor loads, so a single out_ready stall ripples back to in_ready.
    logic s1_load, s2_load, s3_load;

    assign s3_load  = !s3_v_q || out_ready;
    assign s2_load  = !s2_v_q || s3_load;
    assign s1_load  = !s1_v_q || s2_load;
    assign in_ready = s1_load;

    // Partial sum of bits 30..21 of the incoming codeword.
    always_comb begin
        s1_acc_d = {ACC_W{1'b0}};
        for (int i = 21; i < 31; i++) begin
            if (code_in[i]) begin
                s1_acc_d = s1_acc_d + tns_weight(i);
            end else begin
                s1_acc_d = s1_acc_d;
            end
        end
    end

    // Add the weights of bits 20..11, which are held in S1.
    always_comb begin
        s2_acc_d = s1_acc_q;
        for (int i = 11; i < 21; i++) begin
            if (s1_bits_q[i]) begin
                s2_acc_d = s2_acc_d + tns_weight(i);
            end else begin
                s2_acc_d = s2_acc_d;
            end
        end
    end

    // Add the weights of bits 10..0, which are held in S2.
    always_comb begin
        s3_acc_d = s2_acc_q;
        for (int i = 0; i < 11; i++) begin
            if (s2_bits_q[i]) begin
                s3_acc_d = s3_acc_d + tns_weight(i);
            end else begin
                s3_acc_d = s3_acc_d;
            end
        end
    end

    // Advance the pipeline. A stage that loads from an empty predecessor
    // becomes a bubble and keeps its old payload to avoid useless toggling.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s1_acc_q  <= {ACC_W{1'b0}};
            s2_acc_q  <= {ACC_W{1'b0}};
            s3_acc_q  <= {ACC_W{1'b0}};
            s1_bits_q <= 21'd0;
            s2_bits_q <= 11'd0;
        end else begin
            if (s1_load) begin
                s1_v_q <= in_valid;
                if (in_valid) begin
                    s1_acc_q  <= s1_acc_d;
                    s1_bits_q <= code_in[20:0];
                end
            end
            if (s2_load) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_acc_q  <= s2_acc_d;
                    s2_bits_q <= s1_bits_q[10:0];
                end
            end
            if (s3_load) begin
                s3_v_q <= s2_v_q;
                if (s2_v_q) begin
                    s3_acc_q <= s3_acc_d;
                end
            end
        end
    end

    assign data_out  = s3_acc_q[BLEN11_C-1:0];
    assign out_err   = s3_acc_q[ACC_W-1];
    assign out_valid = s3_v_q;

endmodule
